adder_sub_checker: RTL and testbench

//  On-board self-checking stimulus/response engine for the 4-bit adder/subtracter.

---
 rtl/adder_sub_checker.sv | 151 +++++++++++++++
 tb/tb_adder_sub_checker.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/adder_sub_checker.sv
// Self-checking stimulus/response engine for a WIDTH-bit adder/subtracter.
// Sweeps every {as,b,a} combination, waits SETTLE_CYC cycles per vector,
// compares the adder's {c,s} against an internal reference and reports
// pass/fail, the mismatch count and the first failing vector.
module adder_sub_checker #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [WIDTH-1:0]     a,
    output logic [WIDTH-1:0]     b,
    output logic                 as,
    input  logic                 c,
    input  logic [WIDTH-1:0]     s,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH+1:0]   err_cnt,
    output logic [2*WIDTH:0]     fail_vec
);

    localparam int unsigned IW = 2 * WIDTH + 1;
    localparam int unsigned EW = 2 * WIDTH + 2;
    localparam int unsigned CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [IW-1:0]     index_q, index_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              as_q, as_d;
    logic [EW-1:0]     err_q, err_d;
    logic [IW-1:0]     fail_q, fail_d;
    logic [WIDTH:0]    ref_w;
    logic              mismatch;

    // Reference result for the vector currently driven onto the adder
    always_comb begin
        if (as_q) begin
            ref_w = {1'b0, a_q} + {1'b0, ~b_q} + (WIDTH+1)'(1);
        end else begin
            ref_w = {1'b0, a_q} + {1'b0, b_q};
        end
        mismatch = ({c, s} != ref_w);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only honoured from IDLE or DONE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start) state_d = S_DRIVE;
            S_DRIVE:        state_d = S_SETTLE;
            S_SETTLE:       if (cnt_q == LAST_CNT) state_d = S_CHECK;
            S_CHECK:        state_d = (index_q == '1) ? S_DONE : S_DRIVE;
            default:        state_d = S_IDLE;
        endcase
    end

    // Datapath next values: operand drive, settle count, error tracking
    always_comb begin
        index_d = index_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        as_d    = as_q;
        err_d   = err_q;
        fail_d  = fail_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    index_d = '0;
                    cnt_d   = '0;
                    err_d   = '0;
                    fail_d  = '0;
                end
            end
            S_DRIVE: begin
                a_d   = index_q[WIDTH-1:0];
                b_d   = index_q[2*WIDTH-1:WIDTH];
                as_d  = index_q[2*WIDTH];
                cnt_d = '0;
            end
            S_SETTLE: begin
                if (cnt_q != LAST_CNT) cnt_d = cnt_q + CW'(1);
            end
            S_CHECK: begin
                if (mismatch) begin
                    err_d = err_q + EW'(1);
                    if (err_q == '0) fail_d = {as_q, b_q, a_q};
                end
                if (index_q != '1) index_d = index_q + IW'(1);
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index_q <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            as_q    <= 1'b0;
            err_q   <= '0;
            fail_q  <= '0;
        end else begin
            index_q <= index_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            as_q    <= as_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
        end
    end

    // Status outputs decoded from state
    always_comb begin
        busy = (state_q == S_DRIVE) || (state_q == S_SETTLE) || (state_q == S_CHECK);
        done = (state_q == S_DONE);
        pass = (state_q == S_DONE) && (err_q == '0);
    end

    assign a        = a_q;
    assign b        = b_q;
    assign as       = as_q;
    assign err_cnt  = err_q;
    assign fail_vec = fail_q;

endmodule

// File: tb/tb_adder_sub_checker.sv
// Bench for adder_sub_checker: a behavioural adder with selectable faults,
// table-driven sweeps, randomized fault maps and reset/restart corner cases.
module tb_adder_sub_checker;

    localparam int NV    = 512;
    localparam int SWEEP = 2048;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] a_w, b_w, s_w;
    logic       as_w, c_w;
    logic       busy, done, pass;
    logic [9:0] err_cnt;
    logic [8:0] fail_vec;

    int  mode = 0;      // 0 ideal, 1 s[0] stuck 0, 2 c inverted on subtract, 3 random vector faults
    bit  bad [NV];
    int  checks = 0;
    int  errors = 0;

    always #5 clk = ~clk;

    adder_sub_checker #(.WIDTH(4), .SETTLE_CYC(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a(a_w), .b(b_w), .as(as_w), .c(c_w), .s(s_w),
        .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .fail_vec(fail_vec)
    );

    // Ideal adder/subtracter from plain integer arithmetic
    function automatic logic [4:0] ideal_out(input int v);
        int av, bv;
        logic [3:0] d;
        av = v % 16;
        bv = (v / 16) % 16;
        if (v < 256) return 5'(av + bv);
        d = 4'(av - bv);
        return {(av >= bv), d};
    endfunction

    function automatic logic [4:0] faulty_out(input int md, input int v, input bit bad_v);
        logic [4:0] r;
        r = ideal_out(v);
        case (md)
            1: r[0] = 1'b0;
            2: if (v >= 256) r[4] = ~r[4];
            3: if (bad_v) r[0] = ~r[0];
            default: ;
        endcase
        return r;
    endfunction

    // Adder under test
    always_comb begin
        int vi;
        vi = int'({as_w, b_w, a_w});
        {c_w, s_w} = faulty_out(mode, vi, bad[vi]);
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " a/b/as"}, int'({as_w, b_w, a_w}), 0);
        check({tag, " busy/done/pass"}, int'({busy, done, pass}), 0);
        check({tag, " err_cnt"}, int'(err_cnt), 0);
        check({tag, " fail_vec"}, int'(fail_vec), 0);
    endtask

    // Expected outcome of a full sweep under the current fault mode
    task automatic model_sweep(output int exp_err, output int exp_fail);
        exp_err = 0;
        exp_fail = 0;
        for (int v = 0; v < NV; v++) begin
            if (faulty_out(mode, v, bad[v]) != ideal_out(v)) begin
                if (exp_err == 0) exp_fail = v;
                exp_err++;
            end
        end
    endtask

    // Pulse start, then follow the sweep cycle by cycle; n counts edges after the start edge
    task automatic run_sweep(input int restart_at, input int reset_at,
                             output int done_cyc, output int order_err);
        logic [8:0] vec;
        done_cyc = -1;
        order_err = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 1; n <= 3000; n++) begin
            @(posedge clk);
            #1;
            start = (n == restart_at);
            if (n == reset_at) begin
                rst_n = 1'b0;
                #1;
                check_reset_state("async reset");
                start = 1'b0;
                return;
            end
            vec = {as_w, b_w, a_w};
            if (vec != 9'((n - 1) / 4)) order_err++;
            if (n == 1 && (err_cnt != 0 || fail_vec != 0 || done)) order_err++;
            if (done) begin
                done_cyc = n;
                break;
            end
            if (!busy) order_err++;
        end
        start = 1'b0;
    endtask

    typedef struct {
        string name;
        int    md;
        int    exp_err;
        int    exp_fail;
        int    exp_pass;
    } vec_t;

    initial begin
        vec_t tbl [3];
        int done_cyc, order_err, exp_err, exp_fail;

        tbl[0] = '{"ideal",        0, 0,   0,     1};
        tbl[1] = '{"s0 stuck",     1, 256, 9'h001, 0};
        tbl[2] = '{"c inv on sub", 2, 256, 9'h100, 0};

        for (int v = 0; v < NV; v++) bad[v] = 1'b0;

        #23;
        check_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven sweeps with known fault signatures
        for (int k = 0; k < 3; k++) begin
            mode = tbl[k].md;
            run_sweep(0, 0, done_cyc, order_err);
            check({tbl[k].name, " done cycle"}, done_cyc, SWEEP);
            check({tbl[k].name, " sequence/busy"}, order_err, 0);
            check({tbl[k].name, " err_cnt"}, int'(err_cnt), tbl[k].exp_err);
            check({tbl[k].name, " fail_vec"}, int'(fail_vec), tbl[k].exp_fail);
            check({tbl[k].name, " pass"}, int'(pass), tbl[k].exp_pass);
            check({tbl[k].name, " busy low"}, int'(busy), 0);
        end

        // Randomized fault maps against the sweep model
        for (int r = 0; r < 3; r++) begin
            for (int v = 0; v < NV; v++) bad[v] = ($urandom_range(0, 15) == 0);
            mode = 3;
            model_sweep(exp_err, exp_fail);
            run_sweep(0, 0, done_cyc, order_err);
            check("random done cycle", done_cyc, SWEEP);
            check("random sequence/busy", order_err, 0);
            check("random err_cnt", int'(err_cnt), exp_err);
            check("random fail_vec", int'(fail_vec), exp_fail);
            check("random pass", int'(pass), int'(exp_err == 0));
        end

        // Restart from DONE after a failing run: counters clear, clean result
        mode = 1;
        run_sweep(0, 0, done_cyc, order_err);
        check("pre-fix err_cnt", int'(err_cnt), 256);
        mode = 0;
        run_sweep(0, 0, done_cyc, order_err);
        check("restart clears/sequence", order_err, 0);
        check("restart done cycle", done_cyc, SWEEP);
        check("restart err_cnt", int'(err_cnt), 0);
        check("restart pass", int'(pass), 1);

        // Start mid-sweep is ignored
        run_sweep(100, 0, done_cyc, order_err);
        check("ignored start done cycle", done_cyc, SWEEP);
        check("ignored start sequence", order_err, 0);
        check("ignored start pass", int'(pass), 1);

        // Reset at cycle 700 of a failing sweep aborts, then a clean sweep
        mode = 2;
        run_sweep(0, 700, done_cyc, order_err);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post-reset idle busy/done", int'({busy, done}), 0);
        mode = 0;
        run_sweep(0, 0, done_cyc, order_err);
        check("post-reset done cycle", done_cyc, SWEEP);
        check("post-reset sequence", order_err, 0);
        check("post-reset err_cnt", int'(err_cnt), 0);
        check("post-reset pass", int'(pass), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
